// File: rtl/tiny_fpga_cfg_loader.sv
// Bitstream loader: packs an AXI-stream bitstream into per-tile config frames and commits them.
// Optional trailing CRC-8 check is enabled by defining TINY_FPGA_CFG_CRC_EN.
module tiny_fpga_cfg_loader #(
  parameter int unsigned DATA_WIDTH    = 1,
  parameter int unsigned NUM_TILES     = 4,
  parameter int unsigned TILE_CFG_BITS = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tlast,
  output logic [NUM_TILES-1:0]     tile_cfg_we,
  output logic [TILE_CFG_BITS-1:0] tile_cfg_data,
  output logic                     cfg_commit,
  output logic                     cfg_ready,
  output logic                     cfg_busy,
  output logic                     cfg_error
);

  localparam int unsigned BEATS_PER_TILE = TILE_CFG_BITS / DATA_WIDTH;
  localparam int unsigned PAYLOAD_BEATS  = NUM_TILES * BEATS_PER_TILE;
`ifdef TINY_FPGA_CFG_CRC_EN
  localparam int unsigned CRC_BEATS      = 8 / DATA_WIDTH;
`else
  localparam int unsigned CRC_BEATS      = 0;
`endif
  localparam int unsigned TOTAL_BEATS    = PAYLOAD_BEATS + CRC_BEATS;
  localparam int unsigned BEAT_W         = $clog2(TOTAL_BEATS + 1);
  localparam int unsigned TILE_W         = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned BIT_W          = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [TILE_W-1:0]        tile_idx;
  logic [TILE_CFG_BITS-1:0] frame;

  logic                     accept_c;
  logic                     payload_beat_c;
  logic                     last_beat_c;
  logic                     frame_done_c;
  logic                     crc_ok_c;
  logic [TILE_CFG_BITS-1:0] frame_nxt_c;

`ifdef TINY_FPGA_CFG_CRC_EN
  logic [7:0] crc_calc;
  logic [7:0] crc_rx;
  logic [7:0] crc_calc_nxt_c;
  logic [7:0] crc_rx_nxt_c;

  // Serial CRC-8 (poly 0x07) advanced over one beat, earliest bit first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction
`endif

  always_comb begin
    accept_c     = s_tvalid && s_tready;
    last_beat_c  = (beat_cnt == BEAT_W'(TOTAL_BEATS - 1));
    frame_nxt_c  = (frame >> DATA_WIDTH) |
                   (TILE_CFG_BITS'(s_tdata) << (TILE_CFG_BITS - DATA_WIDTH));
`ifdef TINY_FPGA_CFG_CRC_EN
    payload_beat_c = (beat_cnt < BEAT_W'(PAYLOAD_BEATS));
    crc_calc_nxt_c = crc8_step(crc_calc, s_tdata);
    crc_rx_nxt_c   = (crc_rx >> DATA_WIDTH) | (8'(s_tdata) << (8 - DATA_WIDTH));
    crc_ok_c       = (crc_rx_nxt_c == crc_calc);
`else
    payload_beat_c = 1'b1;
    crc_ok_c       = 1'b1;
`endif
    frame_done_c = payload_beat_c && (bit_cnt == BIT_W'(BEATS_PER_TILE - 1));
  end

  // Control FSM; every output is registered and follows the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      beat_cnt      <= '0;
      bit_cnt       <= '0;
      tile_idx      <= '0;
      frame         <= '0;
      s_tready      <= 1'b0;
      tile_cfg_we   <= '0;
      tile_cfg_data <= '0;
      cfg_commit    <= 1'b0;
      cfg_ready     <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_error     <= 1'b0;
`ifdef TINY_FPGA_CFG_CRC_EN
      crc_calc      <= '0;
      crc_rx        <= '0;
`endif
    end else begin
      tile_cfg_we <= '0;
      cfg_commit  <= 1'b0;
      if (cfg) begin
        // Start or restart wins over any beat in the same cycle.
        state     <= S_LOAD;
        beat_cnt  <= '0;
        bit_cnt   <= '0;
        tile_idx  <= '0;
        frame     <= '0;
        s_tready  <= 1'b1;
        cfg_busy  <= 1'b1;
        cfg_ready <= 1'b0;
        cfg_error <= 1'b0;
`ifdef TINY_FPGA_CFG_CRC_EN
        crc_calc  <= '0;
        crc_rx    <= '0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            if (accept_c) begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
              if (payload_beat_c) begin
                frame <= frame_nxt_c;
`ifdef TINY_FPGA_CFG_CRC_EN
                crc_calc <= crc_calc_nxt_c;
`endif
                if (frame_done_c) begin
                  bit_cnt       <= '0;
                  tile_cfg_data <= frame_nxt_c;
                  tile_cfg_we   <= NUM_TILES'(1) << tile_idx;
                  if (tile_idx != TILE_W'(NUM_TILES - 1)) tile_idx <= tile_idx + TILE_W'(1);
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                end
              end
`ifdef TINY_FPGA_CFG_CRC_EN
              else begin
                crc_rx <= crc_rx_nxt_c;
              end
`endif
              if (s_tlast) begin
                s_tready <= 1'b0;
                cfg_busy <= 1'b0;
                if (last_beat_c && crc_ok_c) begin
                  state      <= S_DONE;
                  cfg_commit <= 1'b1;
                  cfg_ready  <= 1'b1;
                end else begin
                  state     <= S_ERROR;
                  cfg_error <= 1'b1;
                end
              end else if (last_beat_c) begin
                state     <= S_DRAIN;
                cfg_error <= 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (accept_c && s_tlast) begin
              state    <= S_ERROR;
              s_tready <= 1'b0;
              cfg_busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tiny_fpga_cfg_loader.sv
// Directed bench for tiny_fpga_cfg_loader; exercises the CRC path when TINY_FPGA_CFG_CRC_EN is defined.
module tb_tiny_fpga_cfg_loader;

`ifdef TINY_FPGA_CFG_CRC_EN
  localparam int DW = 4;
  localparam int CB = 8 / DW;
`else
  localparam int DW = 1;
  localparam int CB = 0;
`endif
  localparam int NT    = 4;
  localparam int TB    = 24;
  localparam int BPT   = TB / DW;
  localparam int P     = NT * BPT;
  localparam int L     = P + CB;
  localparam int ABORT = BPT + 6;

  logic          clk = 1'b0;
  logic          rst, cfg, s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [NT-1:0] tile_cfg_we;
  logic [TB-1:0] tile_cfg_data;
  logic          cfg_commit, cfg_ready, cfg_busy, cfg_error;

  tiny_fpga_cfg_loader #(.DATA_WIDTH(DW), .NUM_TILES(NT), .TILE_CFG_BITS(TB)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .tile_cfg_we(tile_cfg_we),
    .tile_cfg_data(tile_cfg_data), .cfg_commit(cfg_commit), .cfg_ready(cfg_ready),
    .cfg_busy(cfg_busy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc[0:L+8];
  logic [TB-1:0] frames[NT];
  logic [7:0]    crc_exp;

  int            nwe = 0;
  int            ncommit = 0;
  int            commit_cyc = 0;
  logic [NT-1:0] we_val[16];
  logic [TB-1:0] we_data[16];
  int            we_cyc[16];

  // Event log of strobes and commits, sampled just after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (|tile_cfg_we && nwe < 16) begin
      we_val[nwe]  = tile_cfg_we;
      we_data[nwe] = tile_cfg_data;
      we_cyc[nwe]  = cyc;
      nwe++;
    end
    if (cfg_commit) begin
      ncommit++;
      commit_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] beat_data(input int j, input int flip);
    logic [DW-1:0] d;
    logic [TB-1:0] f;
    int g;
    d = '0;
    for (int i = 0; i < DW; i++) begin
      g = (j - 1) * DW + i;
      if (g < P * DW) begin
        f = frames[g / TB];
        d[i] = f[g % TB] ^ (g == flip);
      end else if (g < L * DW) begin
        d[i] = crc_exp[g - P * DW];
      end
    end
    return d;
  endfunction

  task automatic send(input int first, input int n, input int last_at, input bit gaps, input int flip);
    logic rdy;
    for (int j = first; j < first + n; j++) begin
      int waited = 0;
      bit done = 0;
      while (!done) begin
        @(negedge clk);
        rdy = 1'b0;
        if (gaps && waited < 3 && $urandom_range(0, 1) == 1) begin
          s_tvalid = 1'b0;
        end else begin
          s_tvalid = 1'b1;
          s_tdata  = beat_data(j, flip);
          s_tlast  = (j == last_at);
          rdy      = s_tready;
        end
        @(posedge clk);
        #2;
        if (s_tvalid && rdy) begin
          acc_cyc[j] = cyc;
          done = 1;
        end else if (++waited > 40) begin
          chk("beat_accept_timeout", 64'(j), 64'(0));
          @(negedge clk);
          s_tvalid = 1'b0;
          s_tlast  = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse_cfg();
    @(negedge clk);
    cfg = 1'b1;
    @(negedge clk);
    cfg = 1'b0;
  endtask

  task automatic clear_log();
    nwe = 0;
    ncommit = 0;
    commit_cyc = 0;
  endtask

  task automatic chk_clean(input string tag);
    chk({tag, "_nwe"}, 64'(nwe), 64'(NT));
    for (int t = 0; t < NT && t < nwe; t++) begin
      chk({tag, "_we_val"}, 64'(we_val[t]), 64'(1 << t));
      chk({tag, "_we_data"}, 64'(we_data[t]), 64'(frames[t]));
      chk({tag, "_we_cyc"}, 64'(we_cyc[t]), 64'(acc_cyc[(t + 1) * BPT]));
    end
    chk({tag, "_ncommit"}, 64'(ncommit), 64'(1));
    chk({tag, "_commit_cyc"}, 64'(commit_cyc), 64'(acc_cyc[L]));
    chk({tag, "_state"}, 64'({cfg_ready, cfg_busy, cfg_error, s_tready}), 64'(4'b1000));
  endtask

  initial begin
    frames[0] = 24'hA5C31F;
    frames[1] = 24'h0F1E2D;
    frames[2] = 24'h123456;
    frames[3] = 24'hFEDCBA;
    crc_exp = 8'h00;
    for (int g = 0; g < P * DW; g++) begin
      logic [TB-1:0] f;
      logic b;
      f = frames[g / TB];
      b = f[g % TB];
      if (crc_exp[7] ^ b) crc_exp = {crc_exp[6:0], 1'b0} ^ 8'h07;
      else                crc_exp = {crc_exp[6:0], 1'b0};
    end

    rst = 1'b1; cfg = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({s_tready, tile_cfg_we, tile_cfg_data, cfg_commit, cfg_ready, cfg_busy, cfg_error}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", 64'(s_tready), 64'(0));

    // Clean gapless load.
    pulse_cfg();
    chk("start_tready_busy", 64'({s_tready, cfg_busy}), 64'(2'b11));
    clear_log();
    send(1, L, L, 1'b0, -1);
    chk_clean("clean");

    // Clean load with random valid gaps.
    pulse_cfg();
    chk("restart_clears_ready", 64'(cfg_ready), 64'(0));
    clear_log();
    send(1, L, L, 1'b1, -1);
    chk_clean("gaps");

    // Early tlast.
    pulse_cfg();
    clear_log();
    send(1, 2 * BPT + 2, 2 * BPT + 2, 1'b0, -1);
    chk("short_err_tready_busy", 64'({cfg_error, s_tready, cfg_busy, cfg_ready}), 64'(4'b1000));
    chk("short_nwe", 64'(nwe), 64'(2));
    repeat (3) @(negedge clk);
    chk("short_no_commit", 64'(ncommit), 64'(0));
    chk("short_err_sticky", 64'(cfg_error), 64'(1));

    // Missing tlast, then drain until tlast.
    pulse_cfg();
    clear_log();
    send(1, L, 0, 1'b0, -1);
    chk("drain_entry", 64'({cfg_error, cfg_busy, s_tready}), 64'(3'b111));
    chk("drain_nwe", 64'(nwe), 64'(NT));
    send(L + 1, 4, L + 4, 1'b0, -1);
    chk("drain_exit", 64'({cfg_error, cfg_busy, s_tready, cfg_ready}), 64'(4'b1000));
    chk("drain_no_commit", 64'(ncommit), 64'(0));

    // cfg mid-load with a coincident beat, then a clean reload.
    pulse_cfg();
    clear_log();
    send(1, ABORT, 0, 1'b0, -1);
    @(negedge clk);
    cfg = 1'b1; s_tvalid = 1'b1; s_tdata = '1; s_tlast = 1'b0;
    @(negedge clk);
    cfg = 1'b0; s_tvalid = 1'b0;
    chk("abort_nwe", 64'(nwe), 64'(ABORT / BPT));
    chk("abort_no_commit", 64'(ncommit), 64'(0));
    chk("abort_busy", 64'({cfg_busy, s_tready, cfg_error}), 64'(3'b110));
    clear_log();
    send(1, L, L, 1'b0, -1);
    chk_clean("reload");

    // rst mid-load.
    pulse_cfg();
    clear_log();
    send(1, ABORT, 0, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = '1; s_tlast = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 64'({s_tready, tile_cfg_we, tile_cfg_data, cfg_commit, cfg_ready, cfg_busy, cfg_error}), 64'(0));
    rst = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_commit", 64'(ncommit), 64'(0));

`ifdef TINY_FPGA_CFG_CRC_EN
    // One flipped payload bit must fail the CRC.
    pulse_cfg();
    clear_log();
    send(1, L, L, 1'b0, 37);
    chk("crc_bad_state", 64'({cfg_error, cfg_ready, s_tready}), 64'(3'b100));
    chk("crc_bad_nwe", 64'(nwe), 64'(NT));
    repeat (2) @(negedge clk);
    chk("crc_bad_no_commit", 64'(ncommit), 64'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
